// File: rtl/locked_reg_ctrl.sv
// locked_reg_ctrl: write-access controller for a bank of lockable configuration registers.
// Two requesters are round-robin arbitrated. Each granted op goes through a key-sequence
// unlock FSM (LOCKED -> ARMED -> UNLOCKED, with a timed window) and a sticky lock that
// only reset clears.
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   req[1:0]           per-requester request, held until granted
//   key0/key1          1 = key/command op, 0 = register write
//   addr0/addr1        register address
//   wdata0/wdata1      write data or key value
//   gnt[1:0]           one-hot grant, combinational
//   ack/err/resp_id    registered response for the previous cycle's grant
//   reg_we/reg_wdata   registered one-hot write enable and data for the bank
//   unlocked/sticky    state decodes
module locked_reg_ctrl #(
    parameter int unsigned       DW         = 8,
    parameter int unsigned       AW         = 2,
    parameter logic [DW-1:0]     KEY1       = 8'hA5,
    parameter logic [DW-1:0]     KEY2       = 8'h5A,
    parameter logic [DW-1:0]     STICKY_CMD = 8'hFF,
    parameter int unsigned       TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           req,
    input  logic                 key0,
    input  logic                 key1,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        wdata0,
    input  logic [DW-1:0]        wdata1,
    output logic [1:0]           gnt,
    output logic                 ack,
    output logic                 err,
    output logic                 resp_id,
    output logic [(2**AW)-1:0]   reg_we,
    output logic [DW-1:0]        reg_wdata,
    output logic                 unlocked,
    output logic                 sticky
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StLocked, StArmed, StUnlocked, StSticky} state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 rr_q, rr_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 id_q, id_d;
    logic [(2**AW)-1:0]   we_q, we_d;
    logic [DW-1:0]        wdata_q, wdata_d;

    logic                 g_valid;
    logic                 g_id;
    logic                 g_key;
    logic [AW-1:0]        g_addr;
    logic [DW-1:0]        g_data;

    // Arbiter: rr_q names the requester that wins a tie.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr_q ? 2'b10 : 2'b01;
        end
        g_valid = |gnt;
        g_id    = gnt[1];
        g_key   = g_id ? key1 : key0;
        g_addr  = g_id ? addr1 : addr0;
        g_data  = g_id ? wdata1 : wdata0;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rr_d    = rr_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        id_d    = 1'b0;
        we_d    = '0;
        wdata_d = wdata_q;

        // Window countdown; the op granted in the last window cycle still sees UNLOCKED
        // because it is decoded from state_q below.
        if (state_q == StUnlocked && timer_q != '0) begin
            timer_d = timer_q - TW'(1);
            if (timer_q == TW'(1)) begin
                state_d = StLocked;
            end
        end

        if (g_valid) begin
            rr_d = ~g_id;
            id_d = g_id;
            case (state_q)
                StLocked: begin
                    if (g_key && g_data == KEY1) begin
                        state_d = StArmed;
                        ack_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StArmed: begin
                    if (g_key && g_data == KEY2) begin
                        state_d = StUnlocked;
                        timer_d = TW'(TIMEOUT);
                        ack_d   = 1'b1;
                    end else begin
                        state_d = StLocked;
                        err_d   = 1'b1;
                    end
                end
                StUnlocked: begin
                    ack_d = 1'b1;
                    if (!g_key) begin
                        we_d[g_addr] = 1'b1;
                        wdata_d      = g_data;
                    end else if (g_data == STICKY_CMD) begin
                        // Overrides a simultaneous timeout.
                        state_d = StSticky;
                        timer_d = '0;
                    end else begin
                        state_d = StLocked;
                        timer_d = '0;
                    end
                end
                StSticky: begin
                    err_d = 1'b1;
                end
                default: begin
                    state_d = StLocked;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StLocked;
            timer_q <= '0;
            rr_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rr_q    <= rr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            id_q    <= id_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign resp_id   = id_q;
    assign reg_we    = we_q;
    assign reg_wdata = wdata_q;
    assign unlocked  = (state_q == StUnlocked);
    assign sticky    = (state_q == StSticky);

endmodule

// File: tb/tb_locked_reg_ctrl.sv
// Scoreboard bench for locked_reg_ctrl: the driver pushes the expected response of every
// op it issues; a monitor pops and compares whenever the DUT shows a response.
module tb_locked_reg_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] req = '0;
    logic       key0 = 1'b0, key1 = 1'b0;
    logic [1:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic [1:0] gnt;
    logic       ack, err, resp_id;
    logic [3:0] reg_we;
    logic [7:0] reg_wdata;
    logic       unlocked, sticky;

    typedef struct packed {
        logic       ack;
        logic       err;
        logic       id;
        logic [3:0] we;
        logic [7:0] wdata;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    locked_reg_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .key0      (key0),
        .key1      (key1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .ack       (ack),
        .err       (err),
        .resp_id   (resp_id),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .unlocked  (unlocked),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any response cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (ack || err || reg_we != 4'b0) begin
            resp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got ack=%b err=%b id=%b we=%b", ack, err,
                         resp_id, reg_we);
            end else begin
                e = exp_q.pop_front();
                if (ack !== e.ack || err !== e.err || resp_id !== e.id || reg_we !== e.we ||
                    (e.we != 4'b0 && reg_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL resp: got ack=%b err=%b id=%b we=%b wd=%h expected ack=%b err=%b id=%b we=%b wd=%h",
                             ack, err, resp_id, reg_we, reg_wdata,
                             e.ack, e.err, e.id, e.we, e.wdata);
                end
            end
        end
    end

    function automatic resp_t mk(input logic id, input logic k, input logic [1:0] a,
                                 input logic [7:0] d, input logic ok);
        resp_t e;
        e.ack   = ok;
        e.err   = !ok;
        e.id    = id;
        e.we    = (ok && !k) ? (4'b0001 << a) : 4'b0000;
        e.wdata = d;
        return e;
    endfunction

    // Issue one op from a single requester; it is granted in the current cycle.
    task automatic op(input logic id, input logic k, input logic [1:0] a, input logic [7:0] d,
                      input logic ok);
        if (id) begin
            key1 = k; addr1 = a; wdata1 = d; req = 2'b10;
        end else begin
            key0 = k; addr0 = a; wdata0 = d; req = 2'b01;
        end
        exp_q.push_back(mk(id, k, a, d, ok));
        @(posedge clk);
        #1;
        req = 2'b00;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        // Reset with an op granted in the final reset cycle: it must be discarded.
        resetn = 1'b0;
        @(posedge clk);
        #1;
        key0 = 1'b1; wdata0 = 8'hA5; req = 2'b01;
        @(posedge clk);
        #1;
        resetn = 1'b1; req = 2'b00;
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_sticky", sticky, 0);
        // If the reset-cycle KEY1 had been taken, KEY2 would now be acked.
        op(1, 1, 0, 8'h5A, 0);

        // Tie-breaking from a fresh reset.
        do_reset();
        key0 = 0; key1 = 0; addr0 = 1; addr1 = 2;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(i[0], 0, i[0] ? 2'd2 : 2'd1, 8'h00, 0));
            #1;
            chk("gnt_rr", gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
        end
        req = 2'b00;

        // Locked write rejected, then unlock across requesters and write.
        do_reset();
        op(0, 0, 1, 8'h11, 0);
        chk("locked_state", unlocked, 0);
        op(0, 1, 0, 8'hA5, 1);
        op(1, 1, 0, 8'h5A, 1);
        chk("unlocked_after_key2", unlocked, 1);
        op(0, 0, 2, 8'h3C, 1);
        op(1, 1, 0, 8'h00, 1);  // voluntary relock
        chk("relocked", unlocked, 0);

        // Window: KEY2 in cycle G; a mid-window write must not reload the timer.
        op(0, 1, 0, 8'hA5, 1);
        op(1, 1, 0, 8'h5A, 1);   // now in G+1
        repeat (4) @(posedge clk);
        #1;
        op(1, 0, 0, 8'h77, 1);   // G+5
        repeat (10) @(posedge clk);
        #1;
        chk("window_last_unlocked", unlocked, 1);
        op(0, 0, 3, 8'hC3, 1);   // G+16, last window cycle
        chk("window_expired", unlocked, 0);
        op(0, 0, 3, 8'hC4, 0);   // G+17

        // Wrong second key drops back to LOCKED; KEY2 then fails.
        op(0, 1, 0, 8'hA5, 1);
        op(1, 1, 0, 8'h00, 0);
        op(1, 1, 0, 8'h5A, 0);
        chk("armed_fail_state", unlocked, 0);

        // Sticky lock.
        op(0, 1, 0, 8'hA5, 1);
        op(0, 1, 0, 8'h5A, 1);
        op(1, 1, 0, 8'hFF, 1);
        chk("sticky_set", sticky, 1);
        chk("sticky_unlocked", unlocked, 0);
        op(0, 1, 0, 8'hA5, 0);
        op(1, 1, 0, 8'h5A, 0);
        op(0, 0, 1, 8'h99, 0);
        @(posedge clk);
        #1;
        do_reset();
        chk("sticky_cleared", sticky, 0);
        op(0, 1, 0, 8'hA5, 1);   // LOCKED again after reset

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
